// File: rtl/wb_hyper_pkg.sv
// Shared Wishbone/HyperRAM definitions: cycle-type codes and the line buffer FSM states.
package wb_hyper_pkg;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] WB_CTI_INCR    = 3'b010;
  localparam logic [2:0] WB_CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    RESP
  } linebuf_state_t;

endpackage

// File: rtl/wb_hyper_linebuf_mem.sv
// Line storage for wb_hyper_linebuf: LINE_WORDS x 32 registers with a byte-enable
// write port and an asynchronous read port.
module wb_hyper_linebuf_mem #(
  parameter int LINE_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(LINE_WORDS)-1:0] widx,
  input  logic [31:0]                   wdat,
  input  logic [3:0]                    wsel,
  input  logic [$clog2(LINE_WORDS)-1:0] ridx,
  output logic [31:0]                   rdat
);

  logic [31:0] mem [LINE_WORDS];

  // NOTE: the data array has no reset; the buffer's valid bit gates every use of it.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wsel[b]) mem[widx][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

  assign rdat = mem[ridx];

endmodule

// File: rtl/wb_hyper_linebuf.sv
// Single-line write-through read buffer in front of wb_hyper. Optional hit/miss
// counters are built when HYPER_LINEBUF_STATS_EN is defined.
module wb_hyper_linebuf
  import wb_hyper_pkg::*;
#(
  parameter int LINE_WORDS = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic [2:0]  wbm_cti_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        inv_i
`ifdef HYPER_LINEBUF_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int TAG_W = 30 - IDX_W;

  linebuf_state_t   state;
  logic             valid;
  logic [TAG_W-1:0] tag;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic             dropped;
  logic             inv_seen;

  logic             request;
  logic             cpu_hit;
  logic             req_hit;
  logic [IDX_W-1:0] beat_idx;
  logic             last_beat;

  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [31:0]      mem_wdat;
  logic [3:0]       mem_wsel;
  logic [IDX_W-1:0] mem_ridx;
  logic [31:0]      mem_rdat;

  assign request   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  // A same-cycle invalidate turns a would-be hit into a miss.
  assign cpu_hit   = valid & ~inv_i & (wbs_adr_i[31:IDX_W+2] == tag);
  assign req_hit   = valid & ~inv_i & (req_tag == tag);
  assign beat_idx  = wbm_adr_o[IDX_W+1:2];
  assign last_beat = (beat_idx == IDX_W'(LINE_WORDS - 1));
  assign mem_ridx  = (state == IDLE) ? wbs_adr_i[IDX_W+1:2] : req_idx;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    mem_we   = 1'b0;
    mem_widx = beat_idx;
    mem_wdat = wbm_dat_i;
    mem_wsel = 4'hF;
    if (!wb_rst_i && wbm_ack_i) begin
      if (state == FILL) begin
        mem_we = 1'b1;
      end else if (state == WRITE && req_hit) begin
        mem_we   = 1'b1;
        mem_widx = req_idx;
        mem_wdat = wbm_dat_o;
        mem_wsel = wbm_sel_o;
      end
    end
  end

  wb_hyper_linebuf_mem #(.LINE_WORDS(LINE_WORDS)) u_mem (
    .clk  (wb_clk_i),
    .we   (mem_we),
    .widx (mem_widx),
    .wdat (mem_wdat),
    .wsel (mem_wsel),
    .ridx (mem_ridx),
    .rdat (mem_rdat)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      valid     <= 1'b0;
      tag       <= '0;
      req_tag   <= '0;
      req_idx   <= '0;
      dropped   <= 1'b0;
      inv_seen  <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      wbm_cti_o <= WB_CTI_CLASSIC;
      wbm_we_o  <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
    end else begin
      if (inv_i) valid <= 1'b0;
      case (state)
        IDLE: begin
          if (request) begin
            req_tag  <= wbs_adr_i[31:IDX_W+2];
            req_idx  <= wbs_adr_i[IDX_W+1:2];
            dropped  <= 1'b0;
            inv_seen <= 1'b0;
            if (wbs_we_i) begin
              state     <= WRITE;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_we_o  <= 1'b1;
              wbm_adr_o <= wbs_adr_i;
              wbm_dat_o <= wbs_dat_i;
              wbm_sel_o <= wbs_sel_i;
              wbm_cti_o <= WB_CTI_CLASSIC;
            end else if (cpu_hit) begin
              state     <= RESP;
              wbs_ack_o <= 1'b1;
              wbs_dat_o <= mem_rdat;
            end else begin
              state     <= FILL;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_we_o  <= 1'b0;
              wbm_sel_o <= 4'hF;
              wbm_adr_o <= {wbs_adr_i[31:IDX_W+2], {(IDX_W+2){1'b0}}};
              wbm_cti_o <= WB_CTI_INCR;
            end
          end
        end
        FILL: begin
          if (!wbs_cyc_i) dropped <= 1'b1;
          if (inv_i) inv_seen <= 1'b1;
          if (wbm_ack_i) begin
            if (last_beat) begin
              state     <= RESP;
              wbm_cyc_o <= 1'b0;
              wbm_stb_o <= 1'b0;
              wbm_cti_o <= WB_CTI_CLASSIC;
              tag       <= req_tag;
              valid     <= ~(inv_seen | inv_i);
              wbs_ack_o <= ~(dropped | ~wbs_cyc_i);
              // The final beat is still in flight to the array, so forward it directly.
              wbs_dat_o <= (req_idx == beat_idx) ? wbm_dat_i : mem_rdat;
            end else begin
              wbm_adr_o <= wbm_adr_o + 32'd4;
              wbm_cti_o <= (beat_idx == IDX_W'(LINE_WORDS - 2)) ? WB_CTI_EOB : WB_CTI_INCR;
            end
          end
        end
        WRITE: begin
          if (!wbs_cyc_i) dropped <= 1'b1;
          if (wbm_ack_i) begin
            state     <= RESP;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbs_ack_o <= ~(dropped | ~wbs_cyc_i);
          end
        end
        RESP: begin
          state     <= IDLE;
          wbs_ack_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HYPER_LINEBUF_STATS_EN
  logic rd_accept;
  assign rd_accept = (state == IDLE) & request & ~wbs_we_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (rd_accept) begin
      if (cpu_hit) begin
        if (hit_cnt_o != 32'hFFFF_FFFF) hit_cnt_o <= hit_cnt_o + 32'd1;
      end else begin
        if (miss_cnt_o != 32'hFFFF_FFFF) miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_hyper_linebuf.sv
// Self-checking bench for wb_hyper_linebuf: a table of CPU transactions against a
// registered-ack Wishbone memory model, plus cycle-drop and reset-mid-fill sequences.
module tb_wb_hyper_linebuf;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i, wbs_cyc_i, wbs_stb_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [2:0]  wbm_cti_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0;
  logic        inv_i;
`ifdef HYPER_LINEBUF_STATS_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

  always #5 clk = ~clk;

  wb_hyper_linebuf #(.LINE_WORDS(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (wb_rst_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_dat_o (wbs_dat_o),
    .wbs_ack_o (wbs_ack_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_cti_o (wbm_cti_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .inv_i     (inv_i)
`ifdef HYPER_LINEBUF_STATS_EN
    ,
    .hit_cnt_o (hit_cnt_o),
    .miss_cnt_o(miss_cnt_o)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Downstream memory: unwritten words read as 0xD0000000 | address.
  bit          wr_flag [1024];
  logic [31:0] wr_data [1024];
  logic [31:0] log_adr [$];
  logic [2:0]  log_cti [$];
  logic        log_we  [$];
  logic [3:0]  log_sel [$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return wr_flag[a[11:2]] ? wr_data[a[11:2]] : (32'hD000_0000 | a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
      wbm_ack_i <= 1'b1;
      wbm_dat_i <= mem_rd(wbm_adr_o);
      if (wbm_we_o) begin
        wr_flag[wbm_adr_o[11:2]] <= 1'b1;
        wr_data[wbm_adr_o[11:2]] <= merge(mem_rd(wbm_adr_o), wbm_dat_o, wbm_sel_o);
      end
      log_adr.push_back(wbm_adr_o);
      log_cti.push_back(wbm_cti_o);
      log_we.push_back(wbm_we_o);
      log_sel.push_back(wbm_sel_o);
    end else begin
      wbm_ack_i <= 1'b0;
    end
  end

  int edge_n = 0;
  int ack_cnt = 0;
  int last_ack_edge = 0;

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (wbm_ack_i) begin
      ack_cnt       <= ack_cnt + 1;
      last_ack_edge <= edge_n + 1;
    end
  end

  typedef struct {
    string       name;
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    bit          inv_req;
    int          inv_beat;
    logic [31:0] exp_dat;
    int          exp_beats;
  } vec_t;

  function automatic vec_t mkv(input string name, input bit we, input logic [31:0] adr,
                               input logic [31:0] dat, input logic [3:0] sel, input bit inv_req,
                               input int inv_beat, input logic [31:0] exp_dat, input int exp_beats);
    vec_t v;
    v.name = name; v.we = we; v.adr = adr; v.dat = dat; v.sel = sel;
    v.inv_req = inv_req; v.inv_beat = inv_beat; v.exp_dat = exp_dat; v.exp_beats = exp_beats;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int a0, q0, t, req_edge, nb;
    bit got, inv_done;
    logic [31:0] base;
    a0 = ack_cnt;
    q0 = log_adr.size();
    inv_done = 1'b0;
    @(negedge clk);
    wbs_adr_i = v.adr; wbs_dat_i = v.dat; wbs_sel_i = v.we ? v.sel : 4'hF;
    wbs_we_i = v.we; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; inv_i = v.inv_req;
    @(posedge clk); #1;
    inv_i = 1'b0;
    req_edge = edge_n;
    check({v.name, ".cyc"}, wbm_cyc_o, (v.exp_beats > 0));
    got = wbs_ack_o;
    t = 0;
    while (!got && t < 400) begin
      if (v.inv_beat >= 0 && !inv_done && (ack_cnt - a0) == v.inv_beat) begin
        inv_i = 1'b1;
        inv_done = 1'b1;
      end
      @(posedge clk); #1;
      inv_i = 1'b0;
      t++;
      got = wbs_ack_o;
    end
    check({v.name, ".ack"}, got, 1'b1);
    check({v.name, ".beats"}, ack_cnt - a0, v.exp_beats);
    if (v.exp_beats == 0) check({v.name, ".ack_edge"}, edge_n, req_edge);
    else                  check({v.name, ".ack_edge"}, edge_n, last_ack_edge);
    if (!v.we) check({v.name, ".dat"}, wbs_dat_o, v.exp_dat);
    nb = log_adr.size() - q0;
    if (nb > v.exp_beats) nb = v.exp_beats;
    base = v.adr & 32'hFFFF_FFE0;
    for (int k = 0; k < nb; k++) begin
      if (v.we)
        check($sformatf("%s.wr%0d", v.name, k), {log_we[q0+k], log_cti[q0+k], log_sel[q0+k], log_adr[q0+k]},
              {1'b1, 3'b000, v.sel, v.adr});
      else
        check($sformatf("%s.beat%0d", v.name, k), {log_we[q0+k], log_cti[q0+k], log_sel[q0+k], log_adr[q0+k]},
              {1'b0, (k == 7) ? 3'b111 : 3'b010, 4'hF, base + 32'(4 * k)});
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(posedge clk); #1;
    check({v.name, ".ack_pulse"}, wbs_ack_o, 1'b0);
  endtask

  vec_t vecs[$];

  initial begin
    int a0, t;
    bit saw;
    wb_rst_i = 1'b1; inv_i = 1'b0;
    wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0; wbs_we_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.wbs_ack", wbs_ack_o, 1'b0);
    check("rst.wbs_dat", wbs_dat_o, 32'h0);
    check("rst.wbm_ctl", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cti_o, wbm_sel_o}, 10'h0);
    check("rst.wbm_adr", wbm_adr_o, 32'h0);
    @(negedge clk);
    wb_rst_i = 1'b0;

    vecs.push_back(mkv("cold_0x100",  0, 32'h100, 0, 4'h0, 0, -1, 32'hD000_0100, 8));
    vecs.push_back(mkv("hit_0x104",   0, 32'h104, 0, 4'h0, 0, -1, 32'hD000_0104, 0));
    vecs.push_back(mkv("hit_0x11C",   0, 32'h11C, 0, 4'h0, 0, -1, 32'hD000_011C, 0));
    vecs.push_back(mkv("wr_0x108",    1, 32'h108, 32'hAABB_CCDD, 4'b0011, 0, -1, 0, 1));
    vecs.push_back(mkv("merge_0x108", 0, 32'h108, 0, 4'h0, 0, -1, 32'hD000_CCDD, 0));
    vecs.push_back(mkv("miss_0x120",  0, 32'h120, 0, 4'h0, 0, -1, 32'hD000_0120, 8));
    vecs.push_back(mkv("remiss_0x100",0, 32'h100, 0, 4'h0, 0, -1, 32'hD000_0100, 8));
    vecs.push_back(mkv("wr_miss_0x200",1, 32'h200, 32'h1234_5678, 4'hF, 0, -1, 0, 1));
    vecs.push_back(mkv("hit2_0x108",  0, 32'h108, 0, 4'h0, 0, -1, 32'hD000_CCDD, 0));
    vecs.push_back(mkv("miss_0x200",  0, 32'h200, 0, 4'h0, 0, -1, 32'h1234_5678, 8));
    vecs.push_back(mkv("wr_0x204",    1, 32'h204, 32'h1122_3344, 4'b1010, 0, -1, 0, 1));
    vecs.push_back(mkv("merge_0x204", 0, 32'h204, 0, 4'h0, 0, -1, 32'h1100_3304, 0));
    vecs.push_back(mkv("inv_fill",    0, 32'h300, 0, 4'h0, 0,  3, 32'hD000_0300, 8));
    vecs.push_back(mkv("after_inv",   0, 32'h304, 0, 4'h0, 0, -1, 32'hD000_0304, 8));
    vecs.push_back(mkv("inv_w_hit",   0, 32'h308, 0, 4'h0, 1, -1, 32'hD000_0308, 8));
    vecs.push_back(mkv("hit_0x31C",   0, 32'h31C, 0, 4'h0, 0, -1, 32'hD000_031C, 0));
    vecs.push_back(mkv("top_last",    0, 32'hFFFF_FFFC, 0, 4'h0, 0, -1, 32'hFFFF_FFFC, 8));

    foreach (vecs[i]) run_vec(vecs[i]);

    // CPU abandons a read mid-fill: burst completes silently, line still validated.
    a0 = ack_cnt;
    @(negedge clk);
    wbs_adr_i = 32'h500; wbs_we_i = 1'b0; wbs_sel_i = 4'hF; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    t = 0;
    while ((ack_cnt - a0) < 2 && t < 200) begin @(posedge clk); #1; t++; end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    saw = 1'b0; t = 0;
    while (wbm_cyc_o && t < 200) begin
      @(posedge clk); #1;
      if (wbs_ack_o) saw = 1'b1;
      t++;
    end
    check("drop.cyc_done", wbm_cyc_o, 1'b0);
    repeat (4) begin @(posedge clk); #1; if (wbs_ack_o) saw = 1'b1; end
    check("drop.no_ack", saw, 1'b0);
    check("drop.beats", ack_cnt - a0, 8);
    run_vec(mkv("drop.hit", 0, 32'h504, 0, 4'h0, 0, -1, 32'hD000_0504, 0));

    // Reset at beat 3 of a fill.
    a0 = ack_cnt;
    @(negedge clk);
    wbs_adr_i = 32'h600; wbs_we_i = 1'b0; wbs_sel_i = 4'hF; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    t = 0;
    while ((ack_cnt - a0) < 3 && t < 200) begin @(posedge clk); #1; t++; end
    check("rst_fill.beat3", ack_cnt - a0, 3);
    wb_rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge clk); #1;
    check("rst_fill.wbm_ctl", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cti_o}, 6'h0);
    check("rst_fill.wbm_adr", wbm_adr_o, 32'h0);
    check("rst_fill.wbs_ack", wbs_ack_o, 1'b0);
    wb_rst_i = 1'b0;
    saw = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (wbs_ack_o || wbm_cyc_o) saw = 1'b1; end
    check("rst_fill.quiet", saw, 1'b0);
    run_vec(mkv("rst_fill.miss", 0, 32'h504, 0, 4'h0, 0, -1, 32'hD000_0504, 8));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
